smc_pwm_capture: RTL



---
 rtl/smc_pwm_capture_pkg.sv | 28 ++
 rtl/smc_pwm_capture_ch.sv | 104 ++++++++++
 rtl/smc_pwm_capture.sv | 139 +++++++++++++
 3 files changed

// File: rtl/smc_pwm_capture_pkg.sv
// Shared constants, capture record type and counter helper for the SMC PWM capture block.
// Pure declarations: no timing or flow control.
package smc_pwm_capture_pkg;

  localparam int SMC_NCH = 12;
  localparam int CW      = 14;

  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [6:0] ADDR_CTRL         = 7'h00;
  localparam logic [6:0] ADDR_IRQ_EN       = 7'h02;
  localparam logic [6:0] ADDR_VALID        = 7'h04;
  localparam logic [6:0] ADDR_OVR          = 7'h06;
  localparam logic [6:0] ADDR_STUCK        = 7'h08;
  localparam logic [6:0] ADDR_CAP_PER_BASE = 7'h20;
  localparam logic [6:0] ADDR_CAP_HI_BASE  = 7'h40;

  typedef struct packed {
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
    logic          sign;
  } ch_cap_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a, input logic inc);
    return (a == CNT_MAX) ? a : a + {{(CW-1){1'b0}}, inc};
  endfunction

endpackage

// File: rtl/smc_pwm_capture_ch.sv
// One channel: pin-pair decode, period/high counters, arm/stuck tracking, capture register.
// Pins are registered once; a capture lands on the clock edge that sees the decoded rise; never stalls.
module smc_pwm_capture_ch
  import smc_pwm_capture_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    recirc,
  input  logic    mnm,
  input  logic    mnp,
  output ch_cap_t cap,
  output logic    cap_set,
  output logic    cap_rise,
  output logic    stuck
);

  logic          m_q, p_q;
  logic          pwm_q, pwm_q_d;
  logic          sign_q, sign_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic          armed_q, armed_d;
  logic          stuck_q, stuck_d;
  ch_cap_t       cap_q, cap_d;

  logic pwm;
  logic sign;
  logic rise;

  always_comb begin
    pwm  = recirc ? (m_q | p_q) : ~(m_q & p_q);
    // sign is only meaningful while the bridge drives; hold it through off time
    sign = pwm ? m_q : sign_q;
    rise = pwm & ~pwm_q;
  end

  always_comb begin
    pwm_q_d   = pwm;
    sign_d    = sign;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    armed_d   = armed_q;
    stuck_d   = stuck_q;
    cap_d     = cap_q;
    cap_set   = 1'b0;
    cap_rise  = 1'b0;

    if (!en) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      armed_d   = 1'b0;
      stuck_d   = 1'b0;
    end else if (rise) begin
      if (armed_q) begin
        cap_d    = '{per: per_cnt_q, hi: hi_cnt_q, sign: sign};
        cap_set  = 1'b1;
        cap_rise = 1'b1;
      end
      // the rise cycle itself is the first cycle of the new period and is high
      per_cnt_d = {{(CW-1){1'b0}}, 1'b1};
      hi_cnt_d  = {{(CW-1){1'b0}}, 1'b1};
      armed_d   = 1'b1;
      stuck_d   = 1'b0;
    end else begin
      per_cnt_d = sat_inc(per_cnt_q, 1'b1);
      hi_cnt_d  = sat_inc(hi_cnt_q, pwm);
      if ((per_cnt_q == CNT_MAX) && !stuck_q) begin
        stuck_d = 1'b1;
        armed_d = 1'b0;
        cap_d   = '{per: CNT_MAX, hi: (pwm ? CNT_MAX : '0), sign: sign};
        cap_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= 1'b0;
      p_q       <= 1'b0;
      pwm_q     <= 1'b0;
      sign_q    <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      armed_q   <= 1'b0;
      stuck_q   <= 1'b0;
      cap_q     <= '0;
    end else begin
      m_q       <= mnm;
      p_q       <= mnp;
      pwm_q     <= pwm_q_d;
      sign_q    <= sign_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      armed_q   <= armed_d;
      stuck_q   <= stuck_d;
      cap_q     <= cap_d;
    end
  end

  assign cap   = cap_q;
  assign stuck = stuck_q;

endmodule

// File: rtl/smc_pwm_capture.sv
// PWM capture top: NCH channel measurers, q-bus CSRs, valid/overrun flags and capture interrupt.
// qdataout is registered one clock after a read strobe; bus accesses are never stalled.
module smc_pwm_capture
  import smc_pwm_capture_pkg::*;
#(
  parameter int NCH = SMC_NCH
) (
  input  logic           qclk,
  input  logic           qreset,
  input  logic           qsel,
  input  logic           qwrite,
  input  logic [6:0]     qaddr,
  input  logic [15:0]    qdatain,
  output logic [15:0]    qdataout,
  input  logic [NCH-1:0] mnm,
  input  logic [NCH-1:0] mnp,
  output logic           cap_irq
);

  logic           en_q, en_d;
  logic           recirc_q, recirc_d;
  logic [NCH-1:0] irq_en_q, irq_en_d;
  logic [NCH-1:0] valid_q, valid_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic           cap_irq_q, cap_irq_d;
  logic [15:0]    qdataout_q, qdataout_d;

  ch_cap_t        cap [NCH];
  logic [NCH-1:0] cap_set;
  logic [NCH-1:0] cap_rise;
  logic [NCH-1:0] stuck;

  logic           rd_en, wr_en;
  logic [3:0]     idx;
  logic           idx_ok, per_hit, hi_hit;
  logic [NCH-1:0] rd_clr;
  logic [NCH-1:0] w1c;
  logic [15:0]    rd_dat;
  logic           unused_wdat;

  assign unused_wdat = ^qdatain[15:NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    smc_pwm_capture_ch u_ch (
      .clk      (qclk),
      .rst      (qreset),
      .en       (en_q),
      .recirc   (recirc_q),
      .mnm      (mnm[g]),
      .mnp      (mnp[g]),
      .cap      (cap[g]),
      .cap_set  (cap_set[g]),
      .cap_rise (cap_rise[g]),
      .stuck    (stuck[g])
    );
  end

  always_comb begin
    rd_en   = qsel & ~qwrite;
    wr_en   = qsel & qwrite;
    idx     = qaddr[4:1];
    idx_ok  = ~qaddr[0] && ({28'd0, idx} < 32'(NCH));
    per_hit = idx_ok && (qaddr[6:5] == ADDR_CAP_PER_BASE[6:5]);
    hi_hit  = idx_ok && (qaddr[6:5] == ADDR_CAP_HI_BASE[6:5]);
  end

  always_comb begin
    rd_dat = '0;
    case (qaddr)
      ADDR_CTRL:   rd_dat[1:0]     = {recirc_q, en_q};
      ADDR_IRQ_EN: rd_dat[NCH-1:0] = irq_en_q;
      ADDR_VALID:  rd_dat[NCH-1:0] = valid_q;
      ADDR_OVR:    rd_dat[NCH-1:0] = ovr_q;
      ADDR_STUCK:  rd_dat[NCH-1:0] = stuck;
      default: begin
        if (per_hit) begin
          rd_dat[CW-1:0] = cap[idx].per;
        end else if (hi_hit) begin
          rd_dat = {cap[idx].sign, 1'b0, cap[idx].hi};
        end
      end
    endcase
  end

  always_comb begin
    rd_clr = '0;
    if (rd_en && hi_hit) begin
      rd_clr[idx] = 1'b1;
    end
    w1c = (wr_en && (qaddr == ADDR_OVR)) ? qdatain[NCH-1:0] : '0;
  end

  always_comb begin
    en_d       = en_q;
    recirc_d   = recirc_q;
    irq_en_d   = irq_en_q;
    qdataout_d = qdataout_q;

    if (wr_en && (qaddr == ADDR_CTRL)) begin
      en_d     = qdatain[0];
      recirc_d = qdatain[1];
    end
    if (wr_en && (qaddr == ADDR_IRQ_EN)) begin
      irq_en_d = qdatain[NCH-1:0];
    end
    if (rd_en) begin
      qdataout_d = rd_dat;
    end

    // a new capture beats a read-clear; overrun only counts unread data being replaced
    valid_d   = (valid_q & ~rd_clr) | cap_set;
    ovr_d     = (ovr_q & ~w1c) | (cap_rise & valid_q & ~rd_clr);
    cap_irq_d = |(valid_q & irq_en_q);
  end

  always_ff @(posedge qclk or posedge qreset) begin
    if (qreset) begin
      en_q       <= 1'b0;
      recirc_q   <= 1'b0;
      irq_en_q   <= '0;
      valid_q    <= '0;
      ovr_q      <= '0;
      cap_irq_q  <= 1'b0;
      qdataout_q <= '0;
    end else begin
      en_q       <= en_d;
      recirc_q   <= recirc_d;
      irq_en_q   <= irq_en_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      cap_irq_q  <= cap_irq_d;
      qdataout_q <= qdataout_d;
    end
  end

  assign qdataout = qdataout_q;
  assign cap_irq  = cap_irq_q;

endmodule
